frame_sequencer: RTL and testbench

Controls one image frame through the grayscale/edge pipeline. It captures the frame header from the parser and numbers incoming pixels into gray-buffer write addresses. It then steps the Sobel 3x3 window over every interior pixel, generates output-buffer write addresses, and holds the finished frame until the display side acknowledges it. It sits between the parser/rgb2gray stage, the dual-port line buffer, the Sobel core and the VGA output.

---
 rtl/frame_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: numbers gray-buffer writes, steps the Sobel window over interior pixels, holds frame_done until disp_ack.
// Latency: pix_valid -> gray_we 1 cycle; sobel_ready -> out_we 1 cycle; last pixel -> first sobel_start 2 cycles.
// Backpressure: none on pixels (one per cycle accepted); windows advance only on sobel_ready; SEQ_TIMEOUT_EN adds a stall abort.
module frame_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hdr_valid,
    input  logic [15:0] height,
    input  logic [15:0] width,
    input  logic        pix_valid,
    output logic        gray_we,
    output logic [31:0] gray_addr,
    output logic        sobel_start,
    output logic [15:0] read_H,
    output logic [15:0] read_W,
    input  logic        sobel_ready,
    output logic        out_we,
    output logic [31:0] out_addr,
    output logic        frame_done,
    input  logic        disp_ack,
    output logic        busy,
    output logic [1:0]  state,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_FILTER = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_h;
    logic [15:0] r_w;
    logic [31:0] r_total;
    logic [31:0] r_count;
    logic        r_gray_we;
    logic [31:0] r_gray_addr;
    logic        r_sobel_start;
    logic [15:0] r_read_h;
    logic [15:0] r_read_w;
    logic [31:0] r_win_addr;   // linear address of the current window centre
    logic        r_out_we;
    logic [31:0] r_out_addr;   // address presented with out_we (lags r_win_addr by one write)
    logic        r_frame_done;
    logic        r_err;

    logic        w_hdr_acc;
    logic        w_hdr_ok;
    logic        w_pix_acc;
    logic        w_load_end;
    logic        w_rdy_acc;
    logic        w_last_win;
    logic        w_timeout;

    assign w_hdr_acc  = (r_state == S_IDLE) && hdr_valid;
    assign w_hdr_ok   = (height >= 16'd3) && (width >= 16'd3);
    // Pixels beyond the registered total are dropped so the count never overruns.
    assign w_pix_acc  = (r_state == S_LOAD) && pix_valid && (r_count != r_total);
    // Leave LOAD one cycle after the final write has been issued.
    assign w_load_end = (r_state == S_LOAD) && (r_count == r_total);
    // A ready in the sobel_start cycle belongs to the previous window and is discarded.
    assign w_rdy_acc  = (r_state == S_FILTER) && sobel_ready && !r_sobel_start;
    assign w_last_win = (r_read_h == r_h - 16'd2) && (r_read_w == r_w - 16'd2);

`ifdef SEQ_TIMEOUT_EN
    logic [23:0] r_tmo;
`else
    logic        w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    // Next-state decode, with the stall abort overriding normal progress.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE:   if (w_hdr_acc && w_hdr_ok) w_state_nxt = S_LOAD;
            S_LOAD:   if (w_load_end)            w_state_nxt = S_FILTER;
            S_FILTER: if (w_rdy_acc && w_last_win) w_state_nxt = S_DONE;
            S_DONE:   if (disp_ack)              w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
`ifdef SEQ_TIMEOUT_EN
        if (((r_state == S_LOAD) || (r_state == S_FILTER)) && (w_state_nxt == r_state) &&
            !w_pix_acc && !w_rdy_acc && (r_tmo == TIMEOUT_CYCLES - 24'd1)) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

`ifdef SEQ_TIMEOUT_EN
    // Stall counter: restarts on state entry and on every accepted pixel or Sobel result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo <= 24'd0;
        end else if ((w_state_nxt != r_state) || w_pix_acc || w_rdy_acc ||
                     !((r_state == S_LOAD) || (r_state == S_FILTER))) begin
            r_tmo <= 24'd0;
        end else begin
            r_tmo <= r_tmo + 24'd1;
        end
    end
`endif

    // Datapath: header capture, gray addressing, window walk and output strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h           <= 16'd0;
            r_w           <= 16'd0;
            r_total       <= 32'd0;
            r_count       <= 32'd0;
            r_gray_we     <= 1'b0;
            r_gray_addr   <= 32'd0;
            r_sobel_start <= 1'b0;
            r_read_h      <= 16'd0;
            r_read_w      <= 16'd0;
            r_win_addr    <= 32'd0;
            r_out_we      <= 1'b0;
            r_out_addr    <= 32'd0;
            r_frame_done  <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_gray_we     <= 1'b0;
            r_out_we      <= 1'b0;
            r_sobel_start <= 1'b0;
            if (w_timeout) begin
                r_count      <= 32'd0;
                r_gray_addr  <= 32'd0;
                r_read_h     <= 16'd0;
                r_read_w     <= 16'd0;
                r_win_addr   <= 32'd0;
                r_out_addr   <= 32'd0;
                r_frame_done <= 1'b0;
                r_err        <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_hdr_acc) begin
                            r_h <= height;
                            r_w <= width;
                            if (w_hdr_ok) begin
                                r_err   <= 1'b0;
                                r_total <= 32'(height) * 32'(width);
                                r_count <= 32'd0;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (w_pix_acc) begin
                            r_gray_we   <= 1'b1;
                            r_gray_addr <= r_count;
                            r_count     <= r_count + 32'd1;
                        end
                        if (w_load_end) begin
                            r_read_h      <= 16'd1;
                            r_read_w      <= 16'd1;
                            r_win_addr    <= {16'd0, r_w} + 32'd1;
                            r_out_addr    <= {16'd0, r_w} + 32'd1;
                            r_sobel_start <= 1'b1;
                        end
                    end
                    S_FILTER: begin
                        if (w_rdy_acc) begin
                            r_out_we   <= 1'b1;
                            r_out_addr <= r_win_addr;
                            if (w_last_win) begin
                                r_frame_done <= 1'b1;
                            end else begin
                                r_sobel_start <= 1'b1;
                                if (r_read_w < r_w - 16'd2) begin
                                    r_read_w   <= r_read_w + 16'd1;
                                    r_win_addr <= r_win_addr + 32'd1;
                                end else begin
                                    // Skip the right border of this row and the left border of the next.
                                    r_read_w   <= 16'd1;
                                    r_read_h   <= r_read_h + 16'd1;
                                    r_win_addr <= r_win_addr + 32'd3;
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        if (disp_ack) r_frame_done <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign gray_we     = r_gray_we;
    assign gray_addr   = r_gray_addr;
    assign sobel_start = r_sobel_start;
    assign read_H      = r_read_h;
    assign read_W      = r_read_w;
    assign out_we      = r_out_we;
    assign out_addr    = r_out_addr;
    assign frame_done  = r_frame_done;
    assign busy        = (r_state != S_IDLE);
    assign state       = r_state;
    assign err         = r_err;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: reset, 4x4, bad dimensions, back-to-back 5x3, mid-frame reset, optional stall abort.
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Every comparison goes through one checking task that counts and reports mismatches.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hdr_valid = 1'b0;
    logic [15:0] height = 16'd0;
    logic [15:0] width = 16'd0;
    logic        pix_valid = 1'b0;
    logic        gray_we;
    logic [31:0] gray_addr;
    logic        sobel_start;
    logic [15:0] read_H;
    logic [15:0] read_W;
    logic        sobel_ready = 1'b0;
    logic        out_we;
    logic [31:0] out_addr;
    logic        frame_done;
    logic        disp_ack = 1'b0;
    logic        busy;
    logic [1:0]  state;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_addr[8];

    frame_sequencer #(.TIMEOUT_CYCLES(24'd16)) dut (
        .clk(clk), .reset(reset), .hdr_valid(hdr_valid), .height(height), .width(width),
        .pix_valid(pix_valid), .gray_we(gray_we), .gray_addr(gray_addr),
        .sobel_start(sobel_start), .read_H(read_H), .read_W(read_W),
        .sobel_ready(sobel_ready), .out_we(out_we), .out_addr(out_addr),
        .frame_done(frame_done), .disp_ack(disp_ack), .busy(busy), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gray_we"},     32'(gray_we), 0);
        check({tag, ".gray_addr"},   gray_addr, 0);
        check({tag, ".sobel_start"}, 32'(sobel_start), 0);
        check({tag, ".read_H"},      32'(read_H), 0);
        check({tag, ".read_W"},      32'(read_W), 0);
        check({tag, ".out_we"},      32'(out_we), 0);
        check({tag, ".out_addr"},    out_addr, 0);
        check({tag, ".frame_done"},  32'(frame_done), 0);
        check({tag, ".busy"},        32'(busy), 0);
        check({tag, ".state"},       32'(state), 0);
        check({tag, ".err"},         32'(err), 0);
    endtask

    task automatic send_hdr(input int h, input int w);
        hdr_valid = 1'b1;
        height    = 16'(h);
        width     = 16'(w);
        tick();
        hdr_valid = 1'b0;
    endtask

    // Gap style: one pixel every other cycle. Back-to-back: pix_valid held high, with
    // optional spurious hdr_valid/sobel_ready for a few cycles in the middle.
    task automatic load_pix(input int n, input bit b2b, input bit spur);
        if (b2b) begin
            pix_valid = 1'b1;
            for (int i = 0; i < n; i++) begin
                if (spur && i == 3) begin
                    hdr_valid = 1'b1; height = 16'd2; width = 16'd9; sobel_ready = 1'b1;
                end
                if (spur && i == 6) begin
                    hdr_valid = 1'b0; sobel_ready = 1'b0;
                end
                tick();
                check($sformatf("b2b.gray_we[%0d]", i), 32'(gray_we), 1);
                check($sformatf("b2b.gray_addr[%0d]", i), gray_addr, 32'(i));
                if (spur && i == 5) begin
                    check("b2b.state_held", 32'(state), 1);
                    check("b2b.err_clear", 32'(err), 0);
                end
            end
            pix_valid = 1'b0;
            tick();
        end else begin
            for (int i = 0; i < n; i++) begin
                pix_valid = 1'b1;
                tick();
                pix_valid = 1'b0;
                check($sformatf("gap.gray_we[%0d]", i), 32'(gray_we), 1);
                check($sformatf("gap.gray_addr[%0d]", i), gray_addr, 32'(i));
                tick();
                check($sformatf("gap.gray_we_off[%0d]", i), 32'(gray_we), 0);
            end
        end
    endtask

    // Walk up to max_win windows; ready is held two cycles so the first (start-cycle) one is ignored.
    task automatic run_filter(input int h, input int w, input int max_win);
        int k;
        k = 0;
        check("filt.state_entry", 32'(state), 2);
        check("filt.first_out_addr", out_addr, 32'(exp_addr[0]));
        for (int r = 1; r <= h - 2; r++) begin
            for (int c = 1; c <= w - 2; c++) begin
                if (k < max_win) begin
                    check($sformatf("filt.start[%0d]", k), 32'(sobel_start), 1);
                    check($sformatf("filt.read_H[%0d]", k), 32'(read_H), 32'(r));
                    check($sformatf("filt.read_W[%0d]", k), 32'(read_W), 32'(c));
                    sobel_ready = 1'b1;
                    tick();
                    check($sformatf("filt.ready_ignored[%0d]", k), 32'(out_we), 0);
                    tick();
                    sobel_ready = 1'b0;
                    check($sformatf("filt.out_we[%0d]", k), 32'(out_we), 1);
                    check($sformatf("filt.out_addr[%0d]", k), out_addr, 32'(exp_addr[k]));
                    if (r == h - 2 && c == w - 2) begin
                        check("filt.done_state", 32'(state), 3);
                        check("filt.frame_done", 32'(frame_done), 1);
                        check("filt.no_start_after_last", 32'(sobel_start), 0);
                    end
                    k++;
                end
            end
        end
    endtask

    task automatic finish_frame();
        tick();
        tick();
        check("done.hold", 32'(frame_done), 1);
        check("done.busy", 32'(busy), 1);
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        check("done.ack_clears", 32'(frame_done), 0);
        check("done.idle", 32'(state), 0);
    endtask

    initial begin
        // Reset with every input active.
        reset = 1'b1; hdr_valid = 1'b1; height = 16'd4; width = 16'd4;
        pix_valid = 1'b1; sobel_ready = 1'b1; disp_ack = 1'b1;
        tick();
        check_all_zero("reset");
        reset = 1'b0; hdr_valid = 1'b0; pix_valid = 1'b0; sobel_ready = 1'b0; disp_ack = 1'b0;
        tick();

        // 4x4 frame.
        send_hdr(4, 4);
        check("f4.state_load", 32'(state), 1);
        load_pix(16, 1'b0, 1'b0);
        exp_addr[0] = 5; exp_addr[1] = 6; exp_addr[2] = 9; exp_addr[3] = 10;
        run_filter(4, 4, 4);
        finish_frame();

        // Bad dimensions, then a good 3x3 header.
        send_hdr(2, 5);
        check("bad.err", 32'(err), 1);
        check("bad.state", 32'(state), 0);
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        check("bad.no_gray_we", 32'(gray_we), 0);
        send_hdr(3, 3);
        check("f3.err_cleared", 32'(err), 0);
        check("f3.state_load", 32'(state), 1);
        load_pix(9, 1'b0, 1'b0);
        exp_addr[0] = 4;
        run_filter(3, 3, 1);
        finish_frame();

        // Back-to-back 5x3 with spurious inputs during LOAD.
        send_hdr(5, 3);
        load_pix(15, 1'b1, 1'b1);
        exp_addr[0] = 4; exp_addr[1] = 7; exp_addr[2] = 10;
        run_filter(5, 3, 3);
        finish_frame();

        // Reset at the second window of a 4x4 frame, then a fresh 3x3.
        send_hdr(4, 4);
        load_pix(16, 1'b0, 1'b0);
        exp_addr[0] = 5; exp_addr[1] = 6;
        run_filter(4, 4, 1);
        check("midrst.at_second_window", 32'(read_W), 2);
        reset = 1'b1; sobel_ready = 1'b1; pix_valid = 1'b1;
        tick();
        check_all_zero("midrst");
        reset = 1'b0; sobel_ready = 1'b0; pix_valid = 1'b0;
        tick();
        send_hdr(3, 3);
        check("midrst.f3_load", 32'(state), 1);
        load_pix(9, 1'b0, 1'b0);
        exp_addr[0] = 4;
        run_filter(3, 3, 1);
        finish_frame();

`ifdef SEQ_TIMEOUT_EN
        // Stall after 3 pixels of a 4x4 frame; abort lands 16 cycles after the last gray_we.
        send_hdr(4, 4);
        load_pix(3, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        check("tmo.still_load", 32'(state), 1);
        check("tmo.no_err_yet", 32'(err), 0);
        tick();
        check("tmo.err", 32'(err), 1);
        check("tmo.idle", 32'(state), 0);
        check("tmo.gray_addr_clr", gray_addr, 0);
        send_hdr(3, 3);
        check("tmo.err_cleared", 32'(err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
